sram_sp_gen_ext: RTL and testbench
==================================

# sram_sp_gen_ext

Parametrised single-port SRAM model, successor to the fixed-geometry per-array memory models in the core's memory hierarchy. Generalises depth, width, write-lane granularity and read latency. Adds a post-reset clear sequencer, a ready/valid read-return handshake and optional per-lane parity. Drops in wherever a tag or data array macro is instantiated.

## Interface
- DEPTH, 256, number of words; any value ≥ 2
- WIDTH, 72, word width in bits; must be a multiple of LANE_W
- LANE_W, 8, write-mask lane width; NLANES = WIDTH/LANE_W
- READ_LAT, 1, read latency in cycles; legal values 1 or 2
- ADDR_W, $clog2(DEPTH), address width (derived)
- RW0_clk  in  1  single clock; all logic on its rising edge
- RW0_rst_n  in  1  asynchronous active-low reset
- RW0_addr  in  ADDR_W  word address
- RW0_en  in  1  request strobe
- RW0_wmode  in  1  1 = write, 0 = read
- RW0_wmask  in  NLANES  per-lane write enable; ignored for reads
- RW0_wdata  in  WIDTH  write data
- RW0_ready  out  1  request accepted this cycle when RW0_en & RW0_ready
- RW0_rvalid  out  1  one-cycle pulse: RW0_rdata holds a read result
- RW0_rdata  out  WIDTH  read data; holds last result between reads
- RW0_perr  out  NLANES  per-lane parity error, qualified by RW0_rvalid
- init_done  out  1  high once the clear sequence has completed

## Operation
- FSM states: CLEAR, IDLE. Reset enters CLEAR with clear counter = 0.
- CLEAR: writes all-zero data, all lanes, with correct parity, to address = counter; counter increments each cycle. After writing DEPTH-1, go to IDLE; init_done rises. Takes exactly DEPTH cycles. RW0_ready = 0 throughout.
- IDLE: RW0_ready = 1. Requests with RW0_en = 0 or arriving during CLEAR are dropped, not queued.
- Write: for each lane k with wmask[k] = 1, lane k of ram[addr] takes wdata lane k. Unmasked lanes are unchanged. Writes never pulse rvalid or change rdata.
- Read: returns ram[addr] as of the accept cycle. A write in the next cycle to the same address does not alter the returned data.
- Out-of-range address (addr ≥ DEPTH, non-power-of-2 DEPTH only): writes are dropped; reads return 0 with rvalid and perr = 0.
- Reset asserted mid-CLEAR or mid-read: outputs clear immediately, in-flight reads are discarded, CLEAR restarts from address 0. Memory contents are not reset asynchronously; the clear sequence rewrites them.

## Timing
- Reset values: RW0_ready 0, RW0_rvalid 0, RW0_rdata 0, RW0_perr 0, init_done 0.
- Read accepted in cycle N: rvalid/rdata/perr appear in cycle N+READ_LAT.
- Full throughput of one request per cycle in IDLE; back-to-back reads give back-to-back rvalid pulses.
- Write accepted in cycle N is visible to a read accepted in cycle N+1.
- init_done rises in cycle DEPTH after reset deassertion. First accept is possible in that same cycle.

## Configuration
- SRAM_SP_GEN_PARITY_EN defined:
  - Each lane stores one extra even-parity bit, written with the data, so the storage width is WIDTH+NLANES.
  - On read, recomputed parity is compared against the stored bit. RW0_perr[k] = 1 with rvalid on mismatch.
  - A hierarchical-force hook on the stored parity array allows error injection in benches.
- SRAM_SP_GEN_PARITY_EN undefined:
  - No parity storage.
  - RW0_perr is tied to 0.

## Structure
- Package sram_gen_pkg:
  - state enum (CLEAR, IDLE)
  - function computing NLANES
  - function computing per-lane parity
  - legality checks for READ_LAT ∈ {1,2} and WIDTH % LANE_W == 0, as elaboration-time assertions
- Sub-module sram_gen_rdpipe: READ_LAT-deep valid/data/perr pipeline with asynchronous reset and hold-on-idle data. It is instantiated once.

## Test plan
- Release reset, DEPTH=256: ready = 0 for 256 cycles, then init_done = 1. A read of every address returns 0.
- READ_LAT=2: write 0xFF..FF to addr 5 with mask all-ones, then read 5 in cycle N → rvalid and rdata = all-ones at cycle N+2. rdata then holds that value with rvalid = 0.
- Write 0x00 to addr 3, then write 0xAB repeated with wmask = 0x01 → a read of 3 returns 0x..0000AB (lane 0 only).
- Assert reset at clear counter 100, release → clear restarts at 0; init_done rises exactly DEPTH cycles after release.
- Read addr 7, then write addr 7 in the next cycle with new data → rvalid data equals the old value. A following read returns the new value.
- Parity build: force the stored parity of lane 2 at addr 9, then read 9 → RW0_perr = 0x04 with rvalid. Without the macro, perr stays 0.

Source files
------------

// File: rtl/sram_gen_pkg.sv
// sram_gen_pkg: shared state type, lane/parity helpers and configuration
// legality checks for the sram_sp_gen_ext single-port memory model.
package sram_gen_pkg;

  // Sequencer states: CLEAR zero-fills the array after reset, IDLE serves requests.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } sram_state_e;

  // Widest lane the parity helper accepts; lanes are zero-extended to this.
  localparam int MAX_LANE_W = 256;

  // Number of write-mask lanes in a word.
  function automatic int calc_nlanes(input int width, input int lane_w);
    return (lane_w > 0) ? (width / lane_w) : 1;
  endfunction

  // Even parity of one lane. Zero-extension does not change the XOR result.
  function automatic logic lane_parity(input logic [MAX_LANE_W-1:0] lane);
    return ^lane;
  endfunction

  // Read pipeline supports one or two stages.
  function automatic bit read_lat_ok(input int read_lat);
    return (read_lat == 1) || (read_lat == 2);
  endfunction

  // Word must split into whole lanes that the parity helper can handle.
  function automatic bit lane_split_ok(input int width, input int lane_w);
    return (lane_w > 0) && (lane_w <= MAX_LANE_W) && ((width % lane_w) == 0);
  endfunction

  // Array must hold at least two words.
  function automatic bit depth_ok(input int depth);
    return depth >= 2;
  endfunction

endpackage

// File: rtl/sram_gen_rdpipe.sv
// sram_gen_rdpipe: READ_LAT-deep read-return pipeline. Valid advances every
// cycle; data and parity-error words only load behind a valid bit, so the
// last read result is held at the output between reads.
module sram_gen_rdpipe #(
  parameter int READ_LAT = 1,
  parameter int WIDTH    = 72,
  parameter int NLANES   = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capt_valid,
  input  logic [WIDTH-1:0]  capt_data,
  input  logic [NLANES-1:0] capt_perr,
  output logic              rvalid,
  output logic [WIDTH-1:0]  rdata,
  output logic [NLANES-1:0] perr
);

  logic [READ_LAT-1:0] valid_reg;
  logic [WIDTH-1:0]    data_reg [READ_LAT];
  logic [NLANES-1:0]   perr_reg [READ_LAT];

  // Shift valid each cycle; load data/perr into a stage only when it receives a valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      for (int s = 0; s < READ_LAT; s++) begin
        data_reg[s] <= '0;
        perr_reg[s] <= '0;
      end
    end else begin
      valid_reg[0] <= capt_valid;
      if (capt_valid) begin
        data_reg[0] <= capt_data;
        perr_reg[0] <= capt_perr;
      end
      for (int s = 1; s < READ_LAT; s++) begin
        valid_reg[s] <= valid_reg[s-1];
        if (valid_reg[s-1]) begin
          data_reg[s] <= data_reg[s-1];
          perr_reg[s] <= perr_reg[s-1];
        end
      end
    end
  end

  assign rvalid = valid_reg[READ_LAT-1];
  assign rdata  = data_reg[READ_LAT-1];
  assign perr   = perr_reg[READ_LAT-1];

endmodule

// File: rtl/sram_sp_gen_ext.sv
// sram_sp_gen_ext: parametrised single-port SRAM model with lane-masked
// writes, a post-reset zero-fill sequencer, a ready/valid read return and
// optional per-lane even parity (enabled by defining SRAM_SP_GEN_PARITY_EN).
module sram_sp_gen_ext
  import sram_gen_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int WIDTH    = 72,
  parameter int LANE_W   = 8,
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                    RW0_clk,
  input  logic                    RW0_rst_n,
  input  logic [ADDR_W-1:0]       RW0_addr,
  input  logic                    RW0_en,
  input  logic                    RW0_wmode,
  input  logic [WIDTH/LANE_W-1:0] RW0_wmask,
  input  logic [WIDTH-1:0]        RW0_wdata,
  output logic                    RW0_ready,
  output logic                    RW0_rvalid,
  output logic [WIDTH-1:0]        RW0_rdata,
  output logic [WIDTH/LANE_W-1:0] RW0_perr,
  output logic                    init_done
);

  localparam int                NLANES    = calc_nlanes(WIDTH, LANE_W);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Reject unsupported geometries at elaboration time.
  if (!read_lat_ok(READ_LAT)) begin : g_bad_read_lat
    $error("sram_sp_gen_ext: READ_LAT must be 1 or 2");
  end
  if (!lane_split_ok(WIDTH, LANE_W)) begin : g_bad_lanes
    $error("sram_sp_gen_ext: WIDTH must be a multiple of LANE_W");
  end
  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("sram_sp_gen_ext: DEPTH must be at least 2");
  end

  // ------------------------------------------------------------------
  // Clear sequencer
  // ------------------------------------------------------------------
  sram_state_e       state_reg, state_next;
  logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
  logic              clearing;

  // State and clear-address registers; reset restarts the zero-fill at address 0
  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  // Next state, clear-address advance and the ready/init_done handshake outputs
  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    clearing     = 1'b0;
    RW0_ready    = 1'b0;
    init_done    = 1'b0;
    case (state_reg)
      CLEAR: begin
        clearing = 1'b1;
        if (clr_cnt_reg == LAST_ADDR) begin
          state_next   = IDLE;
          clr_cnt_next = '0;
        end else begin
          clr_cnt_next = clr_cnt_reg + 1'b1;
        end
      end
      IDLE: begin
        RW0_ready = 1'b1;
        init_done = 1'b1;
      end
      default: state_next = CLEAR;
    endcase
  end

  // ------------------------------------------------------------------
  // Request decode and shared write port
  // ------------------------------------------------------------------
  logic              accept;
  logic              in_range;
  logic              req_wr;
  logic              req_rd;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [NLANES-1:0] wr_lanes;
  logic [WIDTH-1:0]  wr_data;

  // Requests outside IDLE are dropped simply because ready is low.
  assign accept   = RW0_en & RW0_ready;
  // Only reachable-false for non-power-of-2 depths.
  assign in_range = ({1'b0, RW0_addr} < DEPTH_X);
  assign req_wr   = accept & RW0_wmode & in_range;
  assign req_rd   = accept & ~RW0_wmode;

  // The clear sequencer owns the write port while clearing.
  assign wr_en    = clearing | req_wr;
  assign wr_addr  = clearing ? clr_cnt_reg : RW0_addr;
  assign wr_lanes = clearing ? '1 : RW0_wmask;
  assign wr_data  = clearing ? '0 : RW0_wdata;

  // ------------------------------------------------------------------
  // Data storage
  // ------------------------------------------------------------------
  logic [WIDTH-1:0]  ram [DEPTH];
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_word;

  // Lane-masked write; contents are intentionally not reset, the clear pass rewrites them
  always_ff @(posedge RW0_clk) begin
    if (wr_en) begin
      for (int k = 0; k < NLANES; k++) begin
        if (wr_lanes[k]) begin
          ram[wr_addr][k*LANE_W +: LANE_W] <= wr_data[k*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Out-of-range reads return zero; the index is steered in-bounds regardless.
  assign rd_addr = in_range ? RW0_addr : '0;
  assign rd_word = in_range ? ram[rd_addr] : '0;

  // ------------------------------------------------------------------
  // Optional per-lane parity
  // ------------------------------------------------------------------
  logic [NLANES-1:0] rd_perr;

`ifdef SRAM_SP_GEN_PARITY_EN
  logic [NLANES-1:0] par_mem [DEPTH];
  logic [NLANES-1:0] par_inject;
  logic [NLANES-1:0] wr_par;
  logic [NLANES-1:0] rd_par_calc;

  // Error-injection hook: benches force this to flip the parity bits stored
  // by the next write. Tied inactive in normal operation.
  assign par_inject = '0;

  for (genvar gi = 0; gi < NLANES; gi++) begin : g_par
    assign wr_par[gi]      = lane_parity(MAX_LANE_W'(wr_data[gi*LANE_W +: LANE_W])) ^ par_inject[gi];
    assign rd_par_calc[gi] = lane_parity(MAX_LANE_W'(rd_word[gi*LANE_W +: LANE_W]));
  end

  // Parity bits are written alongside their data lanes
  always_ff @(posedge RW0_clk) begin
    if (wr_en) begin
      for (int k = 0; k < NLANES; k++) begin
        if (wr_lanes[k]) begin
          par_mem[wr_addr][k] <= wr_par[k];
        end
      end
    end
  end

  assign rd_perr = in_range ? (rd_par_calc ^ par_mem[rd_addr]) : '0;
`else
  assign rd_perr = '0;
`endif

  // ------------------------------------------------------------------
  // Read return pipeline (first stage is the registered RAM read)
  // ------------------------------------------------------------------
  sram_gen_rdpipe #(
    .READ_LAT (READ_LAT),
    .WIDTH    (WIDTH),
    .NLANES   (NLANES)
  ) u_rdpipe (
    .clk        (RW0_clk),
    .rst_n      (RW0_rst_n),
    .capt_valid (req_rd),
    .capt_data  (rd_word),
    .capt_perr  (rd_perr),
    .rvalid     (RW0_rvalid),
    .rdata      (RW0_rdata),
    .perr       (RW0_perr)
  );

endmodule

// File: tb/tb_sram_sp_gen_ext.sv
// tb_sram_sp_gen_ext: randomized + directed bench for sram_sp_gen_ext with a
// behavioural memory model and a decoupled read-return scoreboard.
module tb_sram_sp_gen_ext;

  localparam int DEPTH    = 48;
  localparam int WIDTH    = 72;
  localparam int LANE_W   = 8;
  localparam int READ_LAT = 2;
  localparam int AW       = $clog2(DEPTH);
  localparam int NL       = WIDTH / LANE_W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [AW-1:0]   RW0_addr = '0;
  logic            RW0_en = 1'b0;
  logic            RW0_wmode = 1'b0;
  logic [NL-1:0]   RW0_wmask = '0;
  logic [WIDTH-1:0] RW0_wdata = '0;
  logic            RW0_ready;
  logic            RW0_rvalid;
  logic [WIDTH-1:0] RW0_rdata;
  logic [NL-1:0]   RW0_perr;
  logic            init_done;

  always #5 clk = ~clk;

  sram_sp_gen_ext #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .LANE_W   (LANE_W),
    .READ_LAT (READ_LAT),
    .ADDR_W   (AW)
  ) dut (
    .RW0_clk    (clk),
    .RW0_rst_n  (rst_n),
    .RW0_addr   (RW0_addr),
    .RW0_en     (RW0_en),
    .RW0_wmode  (RW0_wmode),
    .RW0_wmask  (RW0_wmask),
    .RW0_wdata  (RW0_wdata),
    .RW0_ready  (RW0_ready),
    .RW0_rvalid (RW0_rvalid),
    .RW0_rdata  (RW0_rdata),
    .RW0_perr   (RW0_perr),
    .init_done  (init_done)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [NL-1:0]    perr;
    int unsigned      due;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: word contents and which lanes hold a corrupted parity bit.
  logic [WIDTH-1:0] model_mem [DEPTH];
  logic [NL-1:0]    model_inj [DEPTH];
  logic [NL-1:0]    inject_now = '0;
  bit               in_reset = 1'b1;
  int unsigned      ready_cyc = 32'hffff_ffff;
  logic [WIDTH-1:0] hold_data = '0;
  logic [NL-1:0]    hold_perr = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0;
      model_inj[i] = '0;
    end
  endtask

  // Drive one request for one cycle and update the model if it will be accepted.
  task automatic issue(input bit en, input bit wm, input int a, input logic [NL-1:0] m,
                       input logic [WIDTH-1:0] d);
    bit model_ready;
    @(posedge clk); #1;
    RW0_en    = en;
    RW0_wmode = wm;
    RW0_addr  = AW'(a);
    RW0_wmask = m;
    RW0_wdata = d;
    model_ready = !in_reset && (cyc >= ready_cyc);
    check("ready", 128'(RW0_ready), 128'(model_ready));
    if (en && model_ready) begin
      if (wm) begin
        $display("wr cyc=%0d addr=%0d mask=%0h data=%0h", cyc, a, m, d);
        if (a < DEPTH) begin
          for (int k = 0; k < NL; k++) begin
            if (m[k]) model_mem[a][k*LANE_W +: LANE_W] = d[k*LANE_W +: LANE_W];
          end
          model_inj[a] = (model_inj[a] & ~m) | (inject_now & m);
        end
      end else begin
        $display("rd cyc=%0d addr=%0d", cyc, a);
        if (a < DEPTH) exp_q.push_back('{data: model_mem[a], perr: model_inj[a], due: cyc + READ_LAT});
        else           exp_q.push_back('{data: '0, perr: '0, due: cyc + READ_LAT});
      end
    end
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, 0, '0, '0);
  endtask

  // Pulse reset, check reset values, release and restart the model's clear timing.
  task automatic do_reset();
    @(posedge clk); #1;
    RW0_en    = 1'b0;
    rst_n     = 1'b0;
    in_reset  = 1'b1;
    exp_q.delete();
    hold_data = '0;
    hold_perr = '0;
    #1;
    check("rst_ready", 128'(RW0_ready), 128'(0));
    check("rst_rvalid", 128'(RW0_rvalid), 128'(0));
    check("rst_rdata", 128'(RW0_rdata), 128'(0));
    check("rst_perr", 128'(RW0_perr), 128'(0));
    check("rst_init_done", 128'(init_done), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    in_reset  = 1'b0;
    ready_cyc = cyc + DEPTH;
    clear_model();
  endtask

  // Count cycles until ready rises while a write is held on the bus (it must be dropped).
  task automatic wait_init();
    int n;
    n = 0;
    RW0_en    = 1'b1;
    RW0_wmode = 1'b1;
    RW0_addr  = '0;
    RW0_wmask = '1;
    RW0_wdata = '1;
    for (int i = 0; i < DEPTH + 16; i++) begin
      @(negedge clk);
      if (RW0_ready) break;
      n++;
    end
    RW0_en = 1'b0;
    check("clear_cycles", 128'(n), 128'(DEPTH));
    check("init_done", 128'(init_done), 128'(1));
  endtask

  // Monitor: compare every cycle's return against the scoreboard head.
  initial begin
    exp_t e;
    bit   exp_v;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        exp_v = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        check("rvalid", 128'(RW0_rvalid), 128'(exp_v));
        if (RW0_rvalid && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rvalid_latency", 128'(cyc), 128'(e.due));
          check("rdata", 128'(RW0_rdata), 128'(e.data));
          check("perr", 128'(RW0_perr), 128'(e.perr));
          $display("ret cyc=%0d data=%0h perr=%0h", cyc, RW0_rdata, RW0_perr);
          hold_data = e.data;
          hold_perr = e.perr;
        end else if (exp_v) begin
          void'(exp_q.pop_front());
        end else if (!RW0_rvalid) begin
          check("rdata_hold", 128'(RW0_rdata), 128'(hold_data));
          check("perr_hold", 128'(RW0_perr), 128'(hold_perr));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit               r_en;
    bit               r_wm;
    int               r_a;
    logic [NL-1:0]    r_m;
    logic [95:0]      r_d;
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] pat_ab;
    ones   = '1;
    pat_ab = {NL{8'hAB}};
    clear_model();

    // Power-up: reset values, clear duration, held write dropped during CLEAR.
    do_reset();
    wait_init();

    // Every in-range address reads back zero after clear.
    for (int a = 0; a < DEPTH; a++) issue(1'b1, 1'b0, a, '0, '0);
    idle();

    // All-ones write then read; hold checked on the idle cycles that follow.
    issue(1'b1, 1'b1, 5, '1, ones);
    issue(1'b1, 1'b0, 5, '0, '0);
    repeat (4) idle();

    // Lane-0-only write over a zeroed word.
    issue(1'b1, 1'b1, 3, '1, '0);
    issue(1'b1, 1'b1, 3, NL'(1), pat_ab);
    issue(1'b1, 1'b0, 3, '0, '0);

    // Read-then-write same address: old data returned, new data on next read.
    issue(1'b1, 1'b1, 7, '1, {NL{8'h11}});
    issue(1'b1, 1'b0, 7, '0, '0);
    issue(1'b1, 1'b1, 7, '1, {NL{8'h22}});
    issue(1'b1, 1'b0, 7, '0, '0);

    // Out-of-range write dropped, out-of-range reads return zero.
    issue(1'b1, 1'b1, DEPTH + 2, '1, ones);
    issue(1'b1, 1'b0, DEPTH + 2, '0, '0);
    issue(1'b1, 1'b0, (1 << AW) - 1, '0, '0);
    issue(1'b1, 1'b0, DEPTH - 1, '0, '0);

    // en low: no request.
    issue(1'b0, 1'b0, 5, '0, '0);
    issue(1'b0, 1'b1, 5, '1, '0);
    repeat (3) idle();

    // Randomized traffic over the full address space.
    for (int i = 0; i < 400; i++) begin
      r_en = ($urandom_range(0, 9) != 0);
      r_wm = ($urandom_range(0, 1) == 1);
      r_a  = int'($urandom_range(0, (1 << AW) - 1));
      r_m  = NL'($urandom());
      r_d  = {$urandom(), $urandom(), $urandom()};
      issue(r_en, r_wm, r_a, r_m, r_d[WIDTH-1:0]);
    end

    // Reset while a read is in flight: the return is discarded, memory re-cleared.
    issue(1'b1, 1'b0, 5, '0, '0);
    do_reset();
    wait_init();
    for (int a = 0; a < 8; a++) issue(1'b1, 1'b0, a, '0, '0);
    repeat (3) idle();

    // Reset partway through CLEAR: the sequence restarts and takes DEPTH cycles again.
    do_reset();
    repeat (20) @(negedge clk);
    do_reset();
    wait_init();
    issue(1'b1, 1'b0, DEPTH - 1, '0, '0);
    issue(1'b1, 1'b0, 0, '0, '0);

`ifdef SRAM_SP_GEN_PARITY_EN
    // Corrupt lane 2's stored parity at address 9 via the injection hook.
    force dut.par_inject = NL'(4);
    inject_now = NL'(4);
    issue(1'b1, 1'b1, 9, '1, {NL{8'h5A}});
    idle();
    release dut.par_inject;
    inject_now = '0;
    issue(1'b1, 1'b0, 9, '0, '0);
    repeat (3) idle();
`endif

    // Drain outstanding returns (bounded).
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) idle();
    check("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
